booth_wallace_pipe: RTL and testbench

- Consumes the eight radix-4 Booth partial products produced by booth2_pp_gen for a 16x16 signed multiply.
- Reduces them through a registered Wallace tree of 3:2 carry-save compressors, then a final carry-propagate adder, to give the 32-bit signed product.
- Three-stage pipeline with valid/ready handshake on both sides. Sits directly downstream of booth2_pp_gen and forms the back end of the MULT16_16 datapath.

---
 rtl/booth_wallace_pipe.sv | 128 ++++++++++++
 tb/tb_booth_wallace_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_wallace_pipe.sv
// Three-stage Wallace-tree reduction of eight radix-4 Booth partial products into a 32-bit signed product.
// Optional running accumulator on delivered products is built when BOOTH_WALLACE_ACC_EN is defined.
module booth_wallace_pipe #(
  parameter int PP_W  = 18,
  parameter int OUT_W = 32
`ifdef BOOTH_WALLACE_ACC_EN
  , parameter int ACC_W = 40
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [PP_W-1:0]  PP1,
  input  logic [PP_W-1:0]  PP2,
  input  logic [PP_W-1:0]  PP3,
  input  logic [PP_W-1:0]  PP4,
  input  logic [PP_W-1:0]  PP5,
  input  logic [PP_W-1:0]  PP6,
  input  logic [PP_W-1:0]  PP7,
  input  logic [PP_W-1:0]  PP8,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] PRODUCT
`ifdef BOOTH_WALLACE_ACC_EN
  , input  logic             ACC_CLR,
  output logic [ACC_W-1:0] ACC_OUT
`endif
);

  typedef logic [OUT_W-1:0] row_t;
  typedef struct packed {
    row_t s;
    row_t c;
  } csa_t;

  // 3:2 compressor; the majority carry out of the top bit falls off the shift.
  function automatic csa_t csa(input row_t a, input row_t b, input row_t c);
    csa_t r;
    r.s = a ^ b ^ c;
    r.c = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

  logic en;
  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;

  logic [PP_W-1:0] pp [8];
  assign pp[0] = PP1;
  assign pp[1] = PP2;
  assign pp[2] = PP3;
  assign pp[3] = PP4;
  assign pp[4] = PP5;
  assign pp[5] = PP6;
  assign pp[6] = PP7;
  assign pp[7] = PP8;

  row_t row [8];
  csa_t l1a, l1b, l2a, l2b;

  // NOTE: every variable gets a full assignment on each pass, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      row[i] = row_t'({{(OUT_W-PP_W){pp[i][PP_W-1]}}, pp[i]}) << (2*i);
    end
    l1a = csa(row[0], row[1], row[2]);
    l1b = csa(row[3], row[4], row[5]);
    l2a = csa(l1a.s, l1a.c, l1b.s);
    l2b = csa(l1b.c, row[6], row[7]);
  end

  row_t q [4];
  logic v1;
  csa_t l3, l4;

  always_comb begin
    l3 = csa(q[0], q[1], q[2]);
    l4 = csa(l3.s, l3.c, q[3]);
  end

  row_t s2_sum, s2_carry;
  logic v2;

  // NOTE: row registers are reset too so that nothing undefined can ever reach PRODUCT.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      OUT_VALID <= 1'b0;
      for (int i = 0; i < 4; i++) q[i] <= '0;
      s2_sum    <= '0;
      s2_carry  <= '0;
      PRODUCT   <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      v1       <= IN_VALID;
      q[0]     <= l2a.s;
      q[1]     <= l2a.c;
      q[2]     <= l2b.s;
      q[3]     <= l2b.c;
      v2       <= v1;
      s2_sum   <= l4.s;
      s2_carry <= l4.c;
      OUT_VALID <= v2;
      // PRODUCT only moves on a real result so it keeps the last one across bubbles.
      if (v2) PRODUCT <= s2_sum + s2_carry;
    end
  end

`ifdef BOOTH_WALLACE_ACC_EN
  logic             out_xfer;
  logic [ACC_W-1:0] prod_ext;
  assign out_xfer = OUT_VALID && OUT_READY;
  assign prod_ext = {{(ACC_W-OUT_W){PRODUCT[OUT_W-1]}}, PRODUCT};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ACC_OUT <= '0;
    end else if (ACC_CLR) begin
      ACC_OUT <= out_xfer ? prod_ext : '0;
    end else if (out_xfer) begin
      ACC_OUT <= ACC_OUT + prod_ext;
    end
  end
`endif

endmodule

// File: tb/tb_booth_wallace_pipe.sv
// Self-checking bench for booth_wallace_pipe: Booth partial products are formed here from operand pairs,
// and results are compared with plain signed multiplication through a latency/stall model and a scoreboard.
module tb_booth_wallace_pipe;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [17:0] pp [8];
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] PRODUCT;
`ifdef BOOTH_WALLACE_ACC_EN
  logic        ACC_CLR = 1'b0;
  logic [39:0] ACC_OUT;
`endif

  always #5 sys_clk = ~sys_clk;

  booth_wallace_pipe dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .PP1      (pp[0]),
    .PP2      (pp[1]),
    .PP3      (pp[2]),
    .PP4      (pp[3]),
    .PP5      (pp[4]),
    .PP6      (pp[5]),
    .PP7      (pp[6]),
    .PP8      (pp[7]),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .PRODUCT  (PRODUCT)
`ifdef BOOTH_WALLACE_ACC_EN
    , .ACC_CLR(ACC_CLR),
    .ACC_OUT  (ACC_OUT)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: three pipeline slots, last delivered product, expected-result queue.
  logic        m_v [3];
  logic [31:0] m_d [3];
  logic [31:0] m_prod;
  logic [31:0] sb [$];
  logic [39:0] m_acc;
  int          n_in, n_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    return 32'(int'($signed(a)) * int'($signed(b)));
  endfunction

  // Radix-4 Booth recoding of b; each partial product is digit * a as an 18-bit value.
  task automatic set_pp(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] bb;
    int sa, d;
    bb = {b, 1'b0};
    sa = int'($signed(a));
    for (int i = 0; i < 8; i++) begin
      d = -2 * int'(bb[2*i+2]) + int'(bb[2*i+1]) + int'(bb[2*i]);
      pp[i] = 18'(d * sa);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_prod = '0;
    m_acc  = '0;
    sb.delete();
    n_in  = 0;
    n_out = 0;
  endtask

  task automatic cycle(input logic rst, input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy, input logic clr, output logic took);
    logic en, oxfer;
    logic [31:0] exp_p;
    @(negedge sys_clk);
    sys_rst   = rst;
    IN_VALID  = iv;
    OUT_READY = ordy;
    set_pp(a, b);
`ifdef BOOTH_WALLACE_ACC_EN
    ACC_CLR = clr;
`endif
    #1;
    en    = !m_v[2] || ordy;
    oxfer = m_v[2] && ordy;
    took  = iv && en && !rst;
    if (!rst) begin
      check("in_ready", IN_READY, en);
      if (OUT_VALID && OUT_READY) begin
        n_out++;
        if (sb.size() == 0) check("sb_extra_result", 64'(sb.size()), 1);
        else begin
          exp_p = sb.pop_front();
          check("sb_order", PRODUCT, exp_p);
        end
      end
    end
    if (rst) begin
      model_clear();
    end else begin
      if (clr) m_acc = oxfer ? {{8{m_prod[31]}}, m_prod} : '0;
      else if (oxfer) m_acc = m_acc + {{8{m_prod[31]}}, m_prod};
      if (en) begin
        if (m_v[2 - 1]) m_prod = m_d[1];
        m_v[2] = m_v[1];
        m_v[1] = m_v[0];
        m_d[1] = m_d[0];
        m_v[0] = iv;
        m_d[0] = ref_mul(a, b);
      end
      if (took) begin
        sb.push_back(ref_mul(a, b));
        n_in++;
      end
    end
    @(posedge sys_clk);
    #1;
    check("out_valid", OUT_VALID, m_v[2]);
    check("product", PRODUCT, m_prod);
`ifdef BOOTH_WALLACE_ACC_EN
    check("acc_out", ACC_OUT, m_acc);
`endif
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic took;
    took = 1'b0;
    for (int t = 0; t < 20 && !took; t++) cycle(1'b0, 1'b1, a, b, 1'b1, 1'b0, took);
    if (!took) check("send_timeout", took, 1);
  endtask

  task automatic idle(input int n);
    logic took;
    for (int t = 0; t < n; t++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, took);
  endtask

  task automatic do_reset();
    logic took;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, took);
  endtask

  logic [15:0] sa_tab [4] = '{16'h8000, 16'h0001, 16'h0009, 16'h0019};
  logic [15:0] sb_tab [4] = '{16'h0019, 16'h0001, 16'h0009, 16'h0019};
  logic [15:0] ca_tab [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
  logic [15:0] cb_tab [4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h8000};

  initial begin
    logic took;
    logic [15:0] ra, rb;
    int idx;

    model_clear();
    do_reset();
    check("reset_in_ready", IN_READY, 1);

    // Back-to-back streaming, then corner operands, each drained.
    for (int i = 0; i < 4; i++) send(sa_tab[i], sb_tab[i]);
    idle(4);
    for (int i = 0; i < 4; i++) send(ca_tab[i], cb_tab[i]);
    idle(4);
    check("stream_drained", 64'(sb.size()), 0);

    // Backpressure: downstream stalls during scenario cycles 4..8.
    idx = 0;
    for (int c = 0; c < 40 && (idx < 5 || sb.size() != 0); c++) begin
      ra = 16'(idx * 16'h1234 + 16'h0F0F);
      rb = 16'(16'hFFF0 - idx * 16'h0321);
      cycle(1'b0, idx < 5, ra, rb, !(c >= 4 && c <= 8), 1'b0, took);
      if (took) idx++;
    end
    check("bp_sent", idx, 5);
    check("bp_count", n_out, n_in);

    // Reset with three results in flight: none of them may appear.
    send(16'h0003, 16'h0005);
    send(16'h0007, 16'hFFFE);
    send(16'h1234, 16'h5678);
    do_reset();
    check("midrst_in_ready", IN_READY, 1);
    idle(5);
    check("midrst_no_result", n_out, 0);

    // Random traffic with random backpressure and gaps.
    for (int c = 0; c < 400; c++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'h7FFF;
      cycle(1'b0, $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 9) < 7, 1'b0, took);
    end
    idle(6);
    check("rand_drained", 64'(sb.size()), 0);
    check("rand_count", n_out, n_in);

`ifdef BOOTH_WALLACE_ACC_EN
    do_reset();
    send(16'h0009, 16'h0009);
    send(16'h8000, 16'h0019);
    send(16'h0019, 16'h0019);
    for (int t = 0; t < 8; t++) begin
      logic clr_now;
      clr_now = m_v[2] && (m_prod == 32'h0000_0271);
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, clr_now, took);
      if (clr_now) check("acc_clr_with_xfer", ACC_OUT, 40'h00_0000_0271);
    end
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, took);
    check("acc_clr_alone", ACC_OUT, 40'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
